// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC and IR.
// CTRL_ILLEGAL_TRAP_EN: undefined opcodes set illegal and park in HALT instead of acting as NOP.
module cpu_ctrl_fsm #(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [31:0]      instr,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic [15:0]      pc,
  output logic [4:0]       ra_addr,
  output logic [4:0]       rb_addr,
  output logic [4:0]       rd_addr,
  output logic [31:0]      imm32,
  output logic [2:0]       alu_op,
  output logic             alu_b_imm,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             illegal
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  localparam logic [5:0] OP_NOP = 6'b000000, OP_J = 6'b000001, OP_MOV = 6'b010000,
    OP_ADD = 6'b010010, OP_SUB = 6'b010011, OP_OR = 6'b010100, OP_AND = 6'b010101,
    OP_SLT = 6'b010111, OP_BEQ = 6'b100000, OP_BNE = 6'b100001, OP_ADDI = 6'b110010,
    OP_SUBI = 6'b110011, OP_ORI = 6'b110100, OP_ANDI = 6'b110101, OP_SLTI = 6'b110111,
    OP_LI = 6'b111001, OP_LWI = 6'b111011, OP_SWI = 6'b111100;
  state_t           state_q, state_d;
  logic [15:0]      pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;
  logic [5:0]       op;
  logic             legal, swap_rd, done;
  assign op = ir_q[31:26];
  assign legal = op inside {OP_NOP, OP_J, OP_MOV, OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLT,
    OP_BEQ, OP_BNE, OP_ADDI, OP_SUBI, OP_ORI, OP_ANDI, OP_SLTI, OP_LI, OP_LWI, OP_SWI};
  assign swap_rd = op inside {OP_BEQ, OP_BNE, OP_SWI};
  assign rd_addr = ir_q[25:21];
  assign ra_addr = swap_rd ? ir_q[25:21] : ir_q[20:16];
  assign rb_addr = swap_rd ? ir_q[20:16] : ir_q[15:11];
  assign imm32 = {(op inside {OP_ORI, OP_ANDI, OP_LI, OP_LWI, OP_SWI, OP_J}) ? 16'h0000 : {16{ir_q[15]}}, ir_q[15:0]};
  // Register and immediate ALU groups share op[2:0]: 010->ADD .. 111->SLT
  assign alu_op = (op == OP_BEQ || op == OP_BNE) ? 3'd2 :
                  op[4:3] != 2'b10 ? 3'd0 :
                  op[2:0] == 3'd7 ? 3'd5 :
                  op[2:0] >= 3'd2 ? op[2:0] - 3'd1 : 3'd0;
  assign alu_b_imm = (state_q == EXEC || state_q == WB) && op[5:3] == 3'b110;
  assign wb_sel = op == OP_LI ? 2'd2 : op == OP_LWI ? 2'd1 : 2'd0;
  assign pc = pc_q;
  assign state = state_q;
  assign retired = retired_q;
  assign illegal = illegal_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    reg_we = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    done = 1'b0;
    case (state_q)
      FETCH: if (run) begin
        ir_d = instr;
        pc_d = pc_q + 16'd1;
        state_d = DECODE;
      end
      DECODE: if (op == OP_NOP) done = 1'b1;
      else if (legal) state_d = EXEC;
`ifdef CTRL_ILLEGAL_TRAP_EN
      else begin
        illegal_d = 1'b1;
        state_d = HALT;
      end
`else
      else done = 1'b1;
`endif
      EXEC: if (op == OP_LWI || op == OP_SWI) state_d = MEM;
      else if (op == OP_BEQ || op == OP_BNE) begin
        if (alu_zero ^ op[0]) pc_d = pc_q + imm32[15:0];
        done = 1'b1;
      end else if (op == OP_J) begin
        pc_d = ir_q[15:0];
        done = 1'b1;
      end else state_d = WB;
      MEM: begin
        mem_rd = op == OP_LWI;
        mem_wr = op == OP_SWI;
        if (mem_ready) begin
          if (op == OP_LWI) state_d = WB;
          else done = 1'b1;
        end
      end
      WB: begin
        reg_we = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
    if (done) begin
      state_d = FETCH;
      retired_d = retired_q + CNT_W'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q <= PC_RESET;
      ir_q <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: directed bench for cpu_ctrl_fsm with a small IMEM model.
module tb_cpu_ctrl_fsm;
  logic        clk = 1'b0, rst_n, run, alu_zero, mem_ready;
  logic [31:0] instr, imm32, retired;
  logic [15:0] pc;
  logic [4:0]  ra_addr, rb_addr, rd_addr;
  logic [2:0]  alu_op, state;
  logic [1:0]  wb_sel;
  logic        alu_b_imm, reg_we, mem_rd, mem_wr, illegal;
  logic [31:0] imem [0:63];
  int          n_chk = 0, n_fail = 0;
  cpu_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .pc(pc), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .rd_addr(rd_addr), .imm32(imm32), .alu_op(alu_op), .alu_b_imm(alu_b_imm),
    .reg_we(reg_we), .wb_sel(wb_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .state(state), .retired(retired), .illegal(illegal)
  );
  always #5 clk = ~clk;
  assign instr = imem[pc[5:0]];
  function automatic logic [31:0] enc(input logic [5:0] o, input logic [4:0] d, input logic [4:0] s, input logic [15:0] i);
    return {o, d, s, i};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    rst_n = 1'b0; run = 1'b0; alu_zero = 1'b0; mem_ready = 1'b0;
    imem[0] = enc(6'b111100, 5'd1, 5'd2, 16'h0010);
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_strobes", 32'({reg_we, mem_rd, mem_wr, alu_b_imm}), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    rst_n = 1'b1; run = 1'b1;
    @(negedge clk);
    chk("swi_state_dec", 32'(state), 32'd1);
    chk("swi_ra", 32'(ra_addr), 32'd1);
    chk("swi_rb", 32'(rb_addr), 32'd2);
    chk("swi_imm", imm32, 32'h10);
    repeat (2) @(negedge clk);
    chk("swi_state_mem", 32'(state), 32'd3);
    chk("swi_mem_wr", 32'(mem_wr), 32'd1);
    chk("swi_mem_rd", 32'(mem_rd), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_mem_wr", 32'(mem_wr), 32'd0);
    chk("async_state", 32'(state), 32'd0);
    chk("async_pc", 32'(pc), 32'd0);
    chk("async_retired", retired, 32'd0);
    imem[0] = 32'h0;
    imem[3] = enc(6'b110010, 5'd1, 5'd1, 16'hFFF8);
    imem[4] = enc(6'b000001, 5'd0, 5'd0, 16'd15);
    imem[15] = enc(6'b100000, 5'd3, 5'd4, 16'd1);
    imem[16] = enc(6'b111011, 5'd14, 5'd0, 16'h0008);
    imem[17] = enc(6'b000001, 5'd0, 5'd0, 16'd15);
    imem[26] = enc(6'b000001, 5'd0, 5'd0, 16'd0);
    alu_zero = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("nop_pc", 32'(pc), 32'd3);
    chk("nop_retired", retired, 32'd3);
    chk("nop_state", 32'(state), 32'd0);
    @(negedge clk);
    chk("addi_imm", imm32, 32'hFFFFFFF8);
    chk("addi_ra", 32'(ra_addr), 32'd1);
    chk("addi_rb", 32'(rb_addr), 32'd31);
    @(negedge clk);
    chk("addi_state_exec", 32'(state), 32'd2);
    chk("addi_alu_op", 32'(alu_op), 32'd1);
    chk("addi_b_imm", 32'(alu_b_imm), 32'd1);
    chk("addi_we_early", 32'(reg_we), 32'd0);
    @(negedge clk);
    chk("addi_state_wb", 32'(state), 32'd4);
    chk("addi_we", 32'(reg_we), 32'd1);
    chk("addi_wb_sel", 32'(wb_sel), 32'd0);
    chk("addi_ret_wb", retired, 32'd3);
    @(negedge clk);
    chk("addi_pc", 32'(pc), 32'd4);
    chk("addi_retired", retired, 32'd4);
    chk("addi_we_off", 32'(reg_we), 32'd0);
    repeat (3) @(negedge clk);
    chk("j15_pc", 32'(pc), 32'd15);
    chk("j15_retired", retired, 32'd5);
    @(negedge clk);
    chk("beq_ra", 32'(ra_addr), 32'd3);
    chk("beq_rb", 32'(rb_addr), 32'd4);
    @(negedge clk);
    chk("beq_state_exec", 32'(state), 32'd2);
    chk("beq_alu_op", 32'(alu_op), 32'd2);
    @(negedge clk);
    chk("beq_taken_pc", 32'(pc), 32'd17);
    chk("beq_taken_state", 32'(state), 32'd0);
    chk("beq_taken_ret", retired, 32'd6);
    repeat (3) @(negedge clk);
    chk("j_back_pc", 32'(pc), 32'd15);
    imem[17] = enc(6'b000001, 5'd0, 5'd0, 16'd26);
    alu_zero = 1'b0;
    repeat (3) @(negedge clk);
    chk("beq_nt_pc", 32'(pc), 32'd16);
    chk("beq_nt_ret", retired, 32'd8);
    chk("beq_nt_state", 32'(state), 32'd0);
    @(negedge clk);
    chk("lwi_rd", 32'(rd_addr), 32'd14);
    chk("lwi_imm", imm32, 32'h8);
    @(negedge clk);
    @(negedge clk);
    chk("lwi_m1_state", 32'(state), 32'd3);
    chk("lwi_m1_rd", 32'(mem_rd), 32'd1);
    @(negedge clk);
    chk("lwi_m2_rd", 32'(mem_rd), 32'd1);
    @(negedge clk);
    chk("lwi_m3_state", 32'(state), 32'd3);
    chk("lwi_m3_rd", 32'(mem_rd), 32'd1);
    mem_ready = 1'b1;
    @(negedge clk);
    chk("lwi_wb_state", 32'(state), 32'd4);
    chk("lwi_wb_rd", 32'(mem_rd), 32'd0);
    chk("lwi_wb_we", 32'(reg_we), 32'd1);
    chk("lwi_wb_sel", 32'(wb_sel), 32'd1);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("lwi_pc", 32'(pc), 32'd17);
    chk("lwi_retired", retired, 32'd9);
    repeat (3) @(negedge clk);
    chk("j26_pc", 32'(pc), 32'd26);
    chk("j26_retired", retired, 32'd10);
    repeat (2) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk("j0_pc", 32'(pc), 32'd0);
    chk("j0_retired", retired, 32'd11);
    repeat (3) @(negedge clk);
    chk("hold_pc", 32'(pc), 32'd0);
    chk("hold_state", 32'(state), 32'd0);
    chk("hold_retired", retired, 32'd11);
    imem[0] = 32'hFC000000;
    run = 1'b1;
    @(negedge clk);
    chk("ill_dec_state", 32'(state), 32'd1);
    chk("ill_dec_pc", 32'(pc), 32'd1);
    @(negedge clk);
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("ill_halt_state", 32'(state), 32'd5);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_retired", retired, 32'd11);
    repeat (2) @(negedge clk);
    chk("halt_state", 32'(state), 32'd5);
    chk("halt_pc", 32'(pc), 32'd1);
    chk("halt_retired", retired, 32'd11);
    chk("halt_strobes", 32'({reg_we, mem_rd, mem_wr, alu_b_imm}), 32'd0);
`else
    chk("ill_nop_state", 32'(state), 32'd0);
    chk("ill_nop_flag", 32'(illegal), 32'd0);
    chk("ill_nop_retired", retired, 32'd12);
    @(negedge clk);
    chk("ill_next_state", 32'(state), 32'd1);
    chk("ill_next_pc", 32'(pc), 32'd2);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the 32-bit, 6-bit-opcode processor core.
- Owns the 16-bit word PC, drives it to the instruction memory and latches the returned word into an internal IR.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives register-file, ALU, data-memory and write-back controls.
- Sits between IMEM and the register file, ALU and data-memory datapath.

Parameters:
- PC_RESET, 16'h0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  allows a new fetch; sampled only in FETCH.
- instr  in  32  instruction word from IMEM at pc.
- alu_zero  in  1  ALU result == 0.
- mem_ready  in  1  data-memory access complete.
- pc  out  16  instruction word address.
- ra_addr  out  5  register read port A address.
- rb_addr  out  5  register read port B address.
- rd_addr  out  5  register write address, ir[25:21].
- imm32  out  32  extended immediate.
- alu_op  out  3  0 PASS_A, 1 ADD, 2 SUB, 3 OR, 4 AND, 5 SLT.
- alu_b_imm  out  1  ALU B operand = imm32.
- reg_we  out  1  register write strobe.
- wb_sel  out  2  0 ALU, 1 MEM, 2 IMM.
- mem_rd  out  1  data-memory read request.
- mem_wr  out  1  data-memory write request.
- state  out  3  FSM state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- retired  out  CNT_W  count of completed instructions.
- illegal  out  1  illegal-opcode flag.

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH, pc=PC_RESET, IR=0, retired=0, illegal=0.
  - reg_we, mem_rd, mem_wr, alu_b_imm all 0 immediately, including mid-MEM.
- Instruction fields: op=ir[31:26], rd=ir[25:21], rs=ir[20:16], rt=ir[15:11], imm=ir[15:0].
- FETCH: if run=1, IR<=instr, pc<=pc+1 (mod 2^16), go to DECODE. If run=0, hold with no fetch.
- DECODE:
  - Computes the read addresses.
  - NOP (000000) retires and returns to FETCH; total 2 cycles.
  - Otherwise goes to EXEC.
- Read addresses:
  - BEQ, BNE, SWI: ra=rd, rb=rs.
  - All other opcodes: ra=rs, rb=rt.
- imm32:
  - Zero-extended for ORI, ANDI, LI, LWI, SWI, J.
  - Sign-extended for all other opcodes.
- EXEC:
  - MOV 010000: PASS_A, then WB(ALU).
  - ADD 010010 / SUB 010011 / OR 010100 / AND 010101 / SLT 010111: register B operand, then WB(ALU).
  - ADDI 110010 / SUBI 110011 / ORI 110100 / ANDI 110101 / SLTI 110111: alu_b_imm=1, then WB(ALU).
  - LI 111001: WB(IMM).
  - LWI 111011 / SWI 111100: go to MEM.
  - BEQ 100000 / BNE 100001: alu_op=SUB. If the branch is taken (alu_zero=1 for BEQ, alu_zero=0 for BNE), pc<=pc+imm32. pc already holds the fetch address +1; wrap mod 2^16. Retire, go to FETCH; 3 cycles.
  - J 000001: pc<=imm[15:0], retire, go to FETCH.
- MEM:
  - mem_rd (LWI) or mem_wr (SWI) is held high every cycle until mem_ready=1.
  - A mem_ready already high on the first MEM cycle completes the access in 1 cycle.
  - SWI then retires and returns to FETCH. LWI goes to WB(MEM).
- WB: reg_we=1 for exactly one cycle, wb_sel per opcode. Retire, go to FETCH. ALU ops take 4 cycles.
- retired: increments by 1 in the final cycle of each instruction and wraps at 2^CNT_W.
- Control outputs are combinational from state and IR. pc, IR, state and retired are registered.
- run deasserted mid-instruction: the instruction completes, then the FSM holds in FETCH.
- Undefined opcodes: handled per CTRL_ILLEGAL_TRAP_EN.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined: an undefined opcode in DECODE sets illegal=1 and moves to HALT. HALT issues no strobes, does not retire and holds pc (the address after the bad word). Only reset exits HALT.
- Undefined: an undefined opcode behaves as NOP (retires, 2 cycles), and illegal is tied to 0.

Test Plan:
- Reset mid-MEM of SWI with mem_ready=0: mem_wr drops to 0 asynchronously; on release pc=0, state=FETCH, retired=0.
- ADDI r1,r1,0xFFF8 at pc=3: imm32=FFFFFFF8, alu_op=ADD, alu_b_imm=1; reg_we pulses in 4th cycle; pc=4.
- BEQ at pc=15 with imm=1 and alu_zero=1: next fetch at pc=17. Same with alu_zero=0: next fetch at pc=16. Each takes 3 cycles.
- LWI r14 from 0x08 with mem_ready delayed 3 cycles: mem_rd high for 3 cycles, then WB with wb_sel=1; total 7 cycles.
- J at pc=26 with imm=0: next pc=0; retired increments once. run=0 before the fetch: pc holds 0 and the state stays FETCH.
- Opcode 111111: with CTRL_ILLEGAL_TRAP_EN, illegal=1, state=HALT and retired unchanged. Without it, retires as NOP.
